// File: rtl/fifo_rd_stream_adapter.sv
// Read-side drain engine for the dual-clock FIFO: issues reads, captures the
// registered FIFO output into a 3-entry skid buffer and presents a framed valid/ready stream.
module fifo_rd_stream_adapter #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned PKT_LEN = 16,
  parameter int unsigned WCNT_W  = 16
) (
  input  logic              r_clk,
  input  logic              r_rst,
  input  logic              enable,
  input  logic              fifo_empty,
  output logic              fifo_rd_en,
  input  logic [WIDTH-1:0]  fifo_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [WIDTH-1:0]  m_data,
  output logic              m_last,
  output logic [WCNT_W-1:0] words_out
);

  localparam int unsigned BEAT_W = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(PKT_LEN - 1);

  logic [WIDTH-1:0]  entry_q [3];
  logic [1:0]        head_q;
  logic [1:0]        tail_q;
  logic [1:0]        cnt_q;
  logic              inflight_q;
  logic [BEAT_W-1:0] beat_q;
  logic [WCNT_W-1:0] words_q;
  logic [2:0]        occupancy;
  logic              push;
  logic              pop;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Buffered words plus the one in flight must never exceed the 3 entries,
  // so the read decision needs no knowledge of m_ready.
  assign occupancy  = {1'b0, cnt_q} + {2'b00, inflight_q};
  assign fifo_rd_en = enable & ~fifo_empty & ~r_rst & (occupancy < 3'd3);

  assign push      = inflight_q;
  assign m_valid   = (cnt_q != 2'd0);
  assign pop       = m_valid & m_ready;
  assign m_data    = entry_q[head_q];
  assign m_last    = m_valid & (beat_q == BEAT_LAST);
  assign words_out = words_q;

  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      for (int unsigned i = 0; i < 3; i++) entry_q[i] <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      cnt_q      <= '0;
      inflight_q <= 1'b0;
      beat_q     <= '0;
      words_q    <= '0;
    end else begin
      inflight_q <= fifo_rd_en;
      if (push) begin
        entry_q[tail_q] <= fifo_data;
        tail_q          <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q  <= ptr_inc(head_q);
        beat_q  <= (beat_q == BEAT_LAST) ? '0 : beat_q + BEAT_W'(1);
        words_q <= words_q + WCNT_W'(1);
      end
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + 2'd1;
        2'b01:   cnt_q <= cnt_q - 2'd1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  a_no_overflow : assert property (@(posedge r_clk) disable iff (r_rst)
    !(push && (cnt_q == 2'd3) && !pop))
    else $error("skid buffer overflow");

endmodule

// File: tb/tb_fifo_rd_stream_adapter.sv
// Bench for fifo_rd_stream_adapter: behavioural FIFO read port feeding a
// scoreboard of words the adapter pulled, checked against the delivered stream.
module tb_fifo_rd_stream_adapter;

  localparam int PKT = 4;

  logic        r_clk = 1'b0;
  logic        r_rst;
  logic        enable;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [31:0] fifo_data = '0;
  logic        m_valid;
  logic        m_ready;
  logic [31:0] m_data;
  logic        m_last;
  logic [15:0] words_out;

  fifo_rd_stream_adapter #(.WIDTH(32), .PKT_LEN(PKT), .WCNT_W(16)) dut (
    .r_clk(r_clk), .r_rst(r_rst), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .fifo_data(fifo_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .words_out(words_out)
  );

  always #5 r_clk = ~r_clk;

  logic [31:0] mem [0:255];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [31:0] exp_q [$];

  assign fifo_empty = (wr_ptr == rd_ptr);

  // FIFO read port: registered data_out, and every served word enters the scoreboard
  always @(posedge r_clk) begin
    if (fifo_rd_en) begin
      fifo_data <= mem[rd_ptr];
      exp_q.push_back(mem[rd_ptr]);
      rd_ptr <= rd_ptr + 1;
    end
  end

  int          n_tests = 0;
  int          n_fail = 0;
  int          beat = 0;
  int          exp_words = 0;
  int          delivered = 0;
  int          rd_cnt = 0;
  int          last_cnt = 0;
  logic [31:0] exp_d;
  logic        hold_pend;
  logic [31:0] hold_d;
  logic        hold_l;

  task automatic step(input logic en, input logic rdy);
    @(negedge r_clk);
    enable  = en;
    m_ready = rdy;
    #1;
  endtask

  task automatic load(input logic [31:0] w);
    mem[wr_ptr] = w;
    wr_ptr++;
  endtask

  task automatic do_reset();
    @(negedge r_clk);
    r_rst = 1'b1; enable = 1'b0; m_ready = 1'b0;
    #1;
    wr_ptr = rd_ptr;
    exp_q.delete();
    beat = 0; exp_words = 0;
    @(negedge r_clk);
    r_rst = 1'b0;
  endtask

  task automatic test_reset();
    r_rst = 1'b1; enable = 1'b1; m_ready = 1'b1;
    repeat (2) @(negedge r_clk);
    #1;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b required 0", m_valid); end
    n_tests++; if (m_last !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b required 0", m_last); end
    n_tests++; if (m_data !== 32'h0) begin n_fail++; $display("FAIL reset_data got %h required 0", m_data); end
    n_tests++; if (words_out !== 16'h0) begin n_fail++; $display("FAIL reset_words got %0d required 0", words_out); end
    load(32'hDEAD_BEEF);
    #1;
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_gate got %b required 0", fifo_rd_en); end
    wr_ptr = rd_ptr;
    @(negedge r_clk);
    r_rst = 1'b0;
    step(1'b1, 1'b1);
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL empty_rd_gate got %b required 0", fifo_rd_en); end
  endtask

  task automatic test_single();
    delivered = 0;
    step(1'b0, 1'b1);
    load(32'hA5A5_0001);
    for (int c = 0; c < 5; c++) begin
      step(1'b1, 1'b1);
      n_tests++; if (fifo_rd_en !== (c == 0)) begin n_fail++; $display("FAIL single_rd_en c%0d got %b required %b", c, fifo_rd_en, c == 0); end
      n_tests++; if (m_valid !== (c == 2)) begin n_fail++; $display("FAIL single_valid c%0d got %b required %b", c, m_valid, c == 2); end
      if (m_valid && m_ready) begin
        n_tests += 3;
        if (exp_q.size() != 0) exp_d = exp_q.pop_front(); else exp_d = 'x;
        if (m_data !== exp_d) begin n_fail++; $display("FAIL single_data got %h required %h", m_data, exp_d); end
        if (m_data !== 32'hA5A5_0001) begin n_fail++; $display("FAIL single_word got %h required a5a50001", m_data); end
        if (m_last !== (beat == PKT - 1)) begin n_fail++; $display("FAIL single_last got %b required %b", m_last, beat == PKT - 1); end
        beat = (beat + 1) % PKT; exp_words++; delivered++;
      end
    end
    n_tests++; if (words_out !== 16'd1) begin n_fail++; $display("FAIL single_words got %0d required 1", words_out); end
  endtask

  task automatic test_stream();
    do_reset();
    delivered = 0; last_cnt = 0;
    for (int i = 0; i < 20; i++) load(32'(i));
    for (int c = 0; c < 25; c++) begin
      step(1'b1, 1'b1);
      n_tests++; if (fifo_rd_en !== (c < 20)) begin n_fail++; $display("FAIL stream_rd_en c%0d got %b required %b", c, fifo_rd_en, c < 20); end
      n_tests++; if (m_valid !== (c >= 2 && c < 22)) begin n_fail++; $display("FAIL stream_valid c%0d got %b required %b", c, m_valid, c >= 2 && c < 22); end
      if (m_valid && m_ready) begin
        n_tests += 2;
        if (exp_q.size() != 0) exp_d = exp_q.pop_front(); else exp_d = 'x;
        if (m_data !== exp_d) begin n_fail++; $display("FAIL stream_data got %h required %h", m_data, exp_d); end
        if (m_last !== (beat == PKT - 1)) begin n_fail++; $display("FAIL stream_last word %0d got %b required %b", delivered, m_last, beat == PKT - 1); end
        if (m_last) last_cnt++;
        beat = (beat + 1) % PKT; exp_words++; delivered++;
      end
    end
    n_tests++; if (delivered != 20) begin n_fail++; $display("FAIL stream_count got %0d required 20", delivered); end
    n_tests++; if (last_cnt != 5) begin n_fail++; $display("FAIL stream_lasts got %0d required 5", last_cnt); end
    n_tests++; if (words_out !== 16'd20) begin n_fail++; $display("FAIL stream_words got %0d required 20", words_out); end
  endtask

  task automatic test_backpressure();
    do_reset();
    delivered = 0; rd_cnt = 0;
    for (int i = 0; i < 10; i++) load(32'h200 + 32'(i));
    for (int c = 0; c < 8; c++) begin
      step(1'b1, 1'b0);
      if (fifo_rd_en) rd_cnt++;
      if (m_valid) begin
        n_tests++; if (m_data !== 32'h200) begin n_fail++; $display("FAIL bp_hold got %h required 00000200", m_data); end
      end
    end
    n_tests++; if (rd_cnt != 3) begin n_fail++; $display("FAIL bp_reads got %0d required 3", rd_cnt); end
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL bp_rd_stall got %b required 0", fifo_rd_en); end
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid got %b required 1", m_valid); end
    for (int c = 0; c < 40 && delivered < 10; c++) begin
      step(1'b1, 1'b1);
      if (m_valid && m_ready) begin
        n_tests += 2;
        if (exp_q.size() != 0) exp_d = exp_q.pop_front(); else exp_d = 'x;
        if (m_data !== exp_d) begin n_fail++; $display("FAIL bp_data got %h required %h", m_data, exp_d); end
        if (m_data !== 32'h200 + 32'(delivered)) begin n_fail++; $display("FAIL bp_order got %h required %h", m_data, 32'h200 + 32'(delivered)); end
        beat = (beat + 1) % PKT; exp_words++; delivered++;
      end
    end
    step(1'b0, 1'b0);
    n_tests++; if (delivered != 10) begin n_fail++; $display("FAIL bp_count got %0d required 10", delivered); end
    n_tests++; if (words_out !== 16'(exp_words)) begin n_fail++; $display("FAIL bp_words got %0d required %0d", words_out, exp_words); end
  endtask

  task automatic test_framing();
    do_reset();
    delivered = 0; last_cnt = 0; hold_pend = 1'b0; hold_d = '0; hold_l = 1'b0;
    for (int i = 0; i < 12; i++) load(32'h300 + 32'(i));
    for (int c = 0; c < 200 && delivered < 12; c++) begin
      step(1'b1, 1'($urandom_range(0, 1)));
      n_tests++; if (m_last && !m_valid) begin n_fail++; $display("FAIL frame_last_idle got %b required 0", m_last); end
      if (hold_pend) begin
        n_tests++;
        if (m_data !== hold_d || m_last !== hold_l) begin n_fail++; $display("FAIL frame_stable got %h/%b required %h/%b", m_data, m_last, hold_d, hold_l); end
      end
      if (m_valid && m_ready) begin
        n_tests += 2;
        if (exp_q.size() != 0) exp_d = exp_q.pop_front(); else exp_d = 'x;
        if (m_data !== exp_d) begin n_fail++; $display("FAIL frame_data got %h required %h", m_data, exp_d); end
        if (m_last !== (delivered % 4 == 3)) begin n_fail++; $display("FAIL frame_last word %0d got %b required %b", delivered, m_last, delivered % 4 == 3); end
        if (m_last) last_cnt++;
        beat = (beat + 1) % PKT; exp_words++; delivered++;
      end
      hold_pend = m_valid && !m_ready; hold_d = m_data; hold_l = m_last;
    end
    n_tests++; if (delivered != 12) begin n_fail++; $display("FAIL frame_count got %0d required 12", delivered); end
    n_tests++; if (last_cnt != 3) begin n_fail++; $display("FAIL frame_lasts got %0d required 3", last_cnt); end
  endtask

  task automatic test_enable_drop();
    do_reset();
    delivered = 0; rd_cnt = 0;
    for (int i = 0; i < 5; i++) load(32'h400 + 32'(i));
    for (int c = 0; c < 10; c++) begin
      step(c < 2, 1'b1);
      if (fifo_rd_en) rd_cnt++;
      if (c >= 2) begin
        n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL en_rd_off c%0d got %b required 0", c, fifo_rd_en); end
      end
      if (m_valid && m_ready) begin
        n_tests++;
        if (exp_q.size() != 0) exp_d = exp_q.pop_front(); else exp_d = 'x;
        if (m_data !== exp_d) begin n_fail++; $display("FAIL en_data got %h required %h", m_data, exp_d); end
        beat = (beat + 1) % PKT; exp_words++; delivered++;
      end
    end
    n_tests++; if (rd_cnt != 2) begin n_fail++; $display("FAIL en_reads got %0d required 2", rd_cnt); end
    n_tests++; if (delivered != 2) begin n_fail++; $display("FAIL en_captured got %0d required 2", delivered); end
    for (int c = 0; c < 30 && delivered < 5; c++) begin
      step(1'b1, 1'b1);
      if (m_valid && m_ready) begin
        n_tests++;
        if (exp_q.size() != 0) exp_d = exp_q.pop_front(); else exp_d = 'x;
        if (m_data !== exp_d) begin n_fail++; $display("FAIL en_data got %h required %h", m_data, exp_d); end
        beat = (beat + 1) % PKT; exp_words++; delivered++;
      end
    end
    n_tests++; if (delivered != 5) begin n_fail++; $display("FAIL en_resume got %0d required 5", delivered); end
  endtask

  task automatic test_reset_mid();
    step(1'b0, 1'b0);
    n_tests++; if (words_out !== 16'd5) begin n_fail++; $display("FAIL mid_pre_words got %0d required 5", words_out); end
    for (int i = 0; i < 10; i++) load(32'h500 + 32'(i));
    repeat (3) step(1'b1, 1'b0);
    @(negedge r_clk);
    #1;
    n_tests++; if (m_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_valid got %b required 1", m_valid); end
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_pre_rd got %b required 0", fifo_rd_en); end
    r_rst = 1'b1;
    #1;
    n_tests++; if (m_valid !== 1'b0) begin n_fail++; $display("FAIL mid_valid got %b required 0", m_valid); end
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL mid_rd_en got %b required 0", fifo_rd_en); end
    n_tests++; if (words_out !== 16'd0) begin n_fail++; $display("FAIL mid_words got %0d required 0", words_out); end
    exp_q.delete();
    beat = 0; exp_words = 0; delivered = 0;
    @(negedge r_clk);
    r_rst = 1'b0;
    for (int i = 10; i < 13; i++) load(32'h500 + 32'(i));
    for (int c = 0; c < 40 && delivered < 10; c++) begin
      step(1'b1, 1'b1);
      if (m_valid && m_ready) begin
        n_tests += 2;
        if (exp_q.size() != 0) exp_d = exp_q.pop_front(); else exp_d = 'x;
        if (m_data !== exp_d) begin n_fail++; $display("FAIL mid_data got %h required %h", m_data, exp_d); end
        if (m_data !== 32'h503 + 32'(delivered)) begin n_fail++; $display("FAIL mid_order got %h required %h", m_data, 32'h503 + 32'(delivered)); end
        beat = (beat + 1) % PKT; exp_words++; delivered++;
      end
    end
    step(1'b0, 1'b0);
    n_tests++; if (delivered != 10) begin n_fail++; $display("FAIL mid_count got %0d required 10", delivered); end
    n_tests++; if (words_out !== 16'd10) begin n_fail++; $display("FAIL mid_post_words got %0d required 10", words_out); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_framing();
    test_enable_drop();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running required finished");
    $fatal(1, "timeout");
  end

endmodule
